// File: rtl/rr_busarb4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_busarb4_pkg
//  Description : Shared constants and state encoding for the four-master
//                round-robin bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_busarb4_pkg;

    localparam int c_nmaster        = 4;
    localparam int c_bus_addr_width = 16;
    localparam int c_data_width     = 32;
    localparam int c_tenure_width   = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_busarb4_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Searches last+1, last+2,
//                last+3, last (mod 4); the first active request wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import rr_busarb4_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       found,
    output logic [1:0] winner
);

    logic [1:0] w_idx;

    // Walk from lowest to highest priority so the highest-priority hit is the final assignment.
    always_comb begin
        found  = 1'b0;
        winner = last;
        w_idx  = 2'd0;
        for (int off = 4; off >= 1; off--) begin
            w_idx = last + 2'(off);
            if (req[w_idx]) begin
                found  = 1'b1;
                winner = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_busarb4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_busarb4
//  Description : Four-master round-robin bus arbiter with shared-bus mux and
//                tenure limit. Idle bus drives address/data 0 and rw_ = 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_busarb4
    import rr_busarb4_pkg::*;
#(
    parameter int NMASTER    = c_nmaster,
    parameter int MAX_TENURE = 16,
    parameter int AW         = c_bus_addr_width,
    parameter int DW         = c_data_width
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [NMASTER-1:0]    breq_,
    input  logic [NMASTER*AW-1:0] addr_m,
    input  logic [NMASTER*DW-1:0] idata_m,
    input  logic [NMASTER-1:0]    rw_m_,
    output logic [NMASTER-1:0]    bgrt_,
    output logic [AW-1:0]         addr,
    output logic [DW-1:0]         idata,
    output logic                  rw_,
    output logic [1:0]            owner,
    output logic                  busy
);

    localparam logic [c_tenure_width-1:0] c_tenure_max = c_tenure_width'(MAX_TENURE);

    arb_state_t                r_state, w_state_nxt;
    logic [1:0]                r_owner, w_owner_nxt;
    logic [1:0]                r_last,  w_last_nxt;
    logic [c_tenure_width-1:0] r_tenure, w_tenure_nxt;
    logic [NMASTER-1:0]        r_bgrt_, w_bgrt_nxt;
    logic                      r_busy;

    logic [3:0] w_req;
    logic [3:0] w_owner_oh;
    logic       w_found;
    logic [1:0] w_winner;
    logic       w_others;
    logic       w_tenure_hit;

    assign w_req        = ~breq_[3:0];
    assign w_owner_oh   = 4'b0001 << r_owner;
    assign w_others     = |(w_req & ~w_owner_oh);
    // The grant cycle now ending is the MAX_TENURE-th one when the count reads MAX_TENURE-1.
    assign w_tenure_hit = (r_tenure >= (c_tenure_max - 8'd1));

    rr_pick u_pick (
        .req    (w_req),
        .last   (r_last),
        .found  (w_found),
        .winner (w_winner)
    );

    // Next-state, owner/pointer update and tenure counting.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_last_nxt   = r_last;
        w_tenure_nxt = r_tenure;
        case (r_state)
            ARB_GRANT: begin
                if (r_tenure != c_tenure_max) begin
                    w_tenure_nxt = r_tenure + 8'd1;
                end
                if (breq_[r_owner]) begin
                    w_state_nxt = ARB_RELEASE;
                end else if (w_tenure_hit && w_others) begin
                    w_state_nxt = ARB_RELEASE;
                end
            end
            default: begin
                if (w_found) begin
                    w_state_nxt  = ARB_GRANT;
                    w_owner_nxt  = w_winner;
                    w_last_nxt   = w_winner;
                    w_tenure_nxt = '0;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
        endcase
        w_bgrt_nxt = '1;
        if (w_state_nxt == ARB_GRANT) begin
            w_bgrt_nxt[w_owner_nxt] = 1'b0;
        end
    end

    // State, pointer, counter and registered grant outputs.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_state  <= ARB_IDLE;
            r_owner  <= 2'd0;
            r_last   <= 2'd3;
            r_tenure <= '0;
            r_bgrt_  <= '1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_last   <= w_last_nxt;
            r_tenure <= w_tenure_nxt;
            r_bgrt_  <= w_bgrt_nxt;
            r_busy   <= (w_state_nxt == ARB_GRANT);
        end
    end

    // Shared-bus mux: owner's signals while granted, a harmless read of address 0 otherwise.
    always_comb begin
        addr  = '0;
        idata = '0;
        rw_   = 1'b1;
        if (r_state == ARB_GRANT) begin
            addr  = addr_m[r_owner*AW +: AW];
            idata = idata_m[r_owner*DW +: DW];
            rw_   = rw_m_[r_owner];
        end
    end

    assign bgrt_ = r_bgrt_;
    assign owner = r_owner;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rr_busarb4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_busarb4
//  Description : Directed self-checking bench for rr_busarb4. Two instances
//                share stimulus: default tenure (16) and a short tenure (4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_busarb4;

    localparam int c_aw = 16;
    localparam int c_dw = 32;

    logic            clk = 1'b0;
    logic            reset_ = 1'b0;
    logic [3:0]      breq_ = 4'b1111;
    logic [4*c_aw-1:0] addr_m;
    logic [4*c_dw-1:0] idata_m;
    logic [3:0]      rw_m_ = 4'b0110;

    logic [3:0]      bgrt16, bgrt4;
    logic [c_aw-1:0] addr16, addr4;
    logic [c_dw-1:0] idata16, idata4;
    logic            rw16, rw4;
    logic [1:0]      owner16, owner4;
    logic            busy16, busy4;

    logic [c_aw-1:0] am [4] = '{16'h0012, 16'h2345, 16'h3456, 16'h4567};
    logic [c_dw-1:0] dm [4] = '{32'hD000_0000, 32'hD111_1111, 32'hD222_2222, 32'hD333_3333};
    int              order [5] = '{0, 1, 2, 3, 0};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_busarb4 #(.MAX_TENURE(16), .AW(c_aw), .DW(c_dw)) dut16 (
        .clk(clk), .reset_(reset_), .breq_(breq_), .addr_m(addr_m), .idata_m(idata_m),
        .rw_m_(rw_m_), .bgrt_(bgrt16), .addr(addr16), .idata(idata16), .rw_(rw16),
        .owner(owner16), .busy(busy16)
    );

    rr_busarb4 #(.MAX_TENURE(4), .AW(c_aw), .DW(c_dw)) dut4 (
        .clk(clk), .reset_(reset_), .breq_(breq_), .addr_m(addr_m), .idata_m(idata_m),
        .rw_m_(rw_m_), .bgrt_(bgrt4), .addr(addr4), .idata(idata4), .rw_(rw4),
        .owner(owner4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        breq_  = 4'b1111;
        reset_ = 1'b0;
        tick();
        reset_ = 1'b1;
    endtask

    initial begin
        addr_m  = {am[3], am[2], am[1], am[0]};
        idata_m = {dm[3], dm[2], dm[1], dm[0]};

        // Reset state
        do_reset();
        chk("rst_bgrt", 32'(bgrt16), 32'hF);
        chk("rst_busy", 32'(busy16), 32'h0);
        chk("rst_owner", 32'(owner16), 32'h0);
        chk("rst_addr", 32'(addr16), 32'h0);
        chk("rst_idata", idata16, 32'h0);
        chk("rst_rw", 32'(rw16), 32'h1);

        // Single requester: master 0 writing to 'h12
        breq_ = 4'b1110;
        tick();
        chk("single_bgrt", 32'(bgrt16), 32'hE);
        chk("single_addr", 32'(addr16), 32'h12);
        chk("single_rw", 32'(rw16), 32'h0);
        chk("single_idata", idata16, 32'hD000_0000);
        chk("single_busy", 32'(busy16), 32'h1);

        // All four request; each releases after two grant cycles
        do_reset();
        breq_ = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            int m;
            m = order[k];
            tick();
            chk("rr_bgrt_a", 32'(bgrt16), 32'(4'b1111 ^ (4'b0001 << m)));
            chk("rr_owner", 32'(owner16), 32'(m));
            chk("rr_addr", 32'(addr16), 32'(am[m]));
            chk("rr_rw", 32'(rw16), 32'(rw_m_[m]));
            tick();
            chk("rr_bgrt_b", 32'(bgrt16), 32'(4'b1111 ^ (4'b0001 << m)));
            breq_[m] = 1'b1;
            tick();
            chk("rr_gap_bgrt", 32'(bgrt16), 32'hF);
            chk("rr_gap_busy", 32'(busy16), 32'h0);
            chk("rr_gap_addr", 32'(addr16), 32'h0);
            breq_ = 4'b0000;
        end

        // Tenure limit 4: master 2 hogs while master 3 waits
        do_reset();
        breq_ = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("ten_m2_bgrt", 32'(bgrt4), 32'hB);
        end
        tick();
        chk("ten_gap_bgrt", 32'(bgrt4), 32'hF);
        tick();
        chk("ten_m3_bgrt", 32'(bgrt4), 32'h7);
        chk("ten_m3_owner", 32'(owner4), 32'h3);
        tick();
        chk("ten_m3_hold", 32'(bgrt4), 32'h7);
        breq_ = 4'b1011;
        tick();
        chk("ten_gap2_bgrt", 32'(bgrt4), 32'hF);
        tick();
        chk("ten_m2_again", 32'(bgrt4), 32'hB);
        chk("ten_m2_owner", 32'(owner4), 32'h2);

        // Lone hog: master 1 alone keeps the bus past any tenure limit
        do_reset();
        breq_ = 4'b1101;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("hog_bgrt16", 32'(bgrt16), 32'hD);
            chk("hog_bgrt4", 32'(bgrt4), 32'hD);
        end

        // Reset in the middle of master 3 writing
        do_reset();
        breq_ = 4'b0111;
        tick();
        chk("mid_bgrt", 32'(bgrt16), 32'h7);
        chk("mid_rw", 32'(rw16), 32'h0);
        chk("mid_idata", idata16, 32'hD333_3333);
        reset_ = 1'b0;
        tick();
        chk("mid_rst_bgrt", 32'(bgrt16), 32'hF);
        chk("mid_rst_rw", 32'(rw16), 32'h1);
        chk("mid_rst_busy", 32'(busy16), 32'h0);
        chk("mid_rst_addr", 32'(addr16), 32'h0);
        reset_ = 1'b1;
        breq_  = 4'b0000;
        tick();
        chk("mid_after_bgrt", 32'(bgrt16), 32'hE);

        // Glitch request from master 2 while master 0 owns the bus
        do_reset();
        breq_ = 4'b1110;
        tick();
        chk("gl_m0_bgrt", 32'(bgrt16), 32'hE);
        breq_ = 4'b1010;
        tick();
        chk("gl_hold_bgrt", 32'(bgrt16), 32'hE);
        breq_ = 4'b1110;
        tick();
        chk("gl_hold2_bgrt", 32'(bgrt16), 32'hE);
        breq_ = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("gl_none_bgrt", 32'(bgrt16), 32'hF);
            chk("gl_none_busy", 32'(busy16), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
